inst_rom_loader: RTL and testbench

- Instruction-memory responder for the CPU fetch port. It answers the CPU's chip-enable and PC fetch with 32-bit instruction words.
- Also provides a byte-serial program-load port. A boot host streams bytes that are packed big-endian into words and written sequentially from word 0.
- Sits beside the CPU top level, on the other end of the CPU's ROM address, chip-enable and data interface.
- Fetch is combinational, so the CPU's IF/ID register samples valid data in the same cycle the PC is presented.

---
 rtl/inst_rom_loader_pkg.sv | 7 +
 rtl/inst_rom_loader_mem_array.sv | 19 +
 rtl/inst_rom_loader.sv | 99 +++++++++
 tb/tb_inst_rom_loader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// inst_rom_loader_pkg: shared state encodings and constants for the instruction ROM loader.
package inst_rom_loader_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, RUN = 2'd3} state_e;
    localparam int InstBusW = 32;
    localparam logic [InstBusW-1:0] ZeroWord = '0;
    localparam logic RstEnable = 1'b0;
endpackage

// File: rtl/inst_rom_loader_mem_array.sv
// inst_mem_array: instruction storage with one synchronous write port and one combinational read port.
module inst_mem_array
    import inst_rom_loader_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [InstBusW-1:0] wdata_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [InstBusW-1:0] rdata_o
);
    logic [InstBusW-1:0] mem_q [2**AW];
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: CPU instruction fetch responder with a byte-serial big-endian program-load port.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ce_i,
    input  logic [31:0]         addr_i,
    output logic [InstBusW-1:0] inst_o,
    input  logic                load_start_i,
    input  logic                load_valid_i,
    input  logic [7:0]          load_byte_i,
    output logic                load_ready_o,
    input  logic                load_end_i,
    output logic                run_o,
    output logic [AW:0]         words_loaded_o
);
    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d, pad;
    logic [AW:0]         waddr_q, waddr_d, words_q, words_d;
    logic [31:0]         shift_q, shift_d;
    logic                we;
    logic [31:0]         wdata, rdata;
    logic                unused_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (rst_ni == RstEnable) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            words_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            words_q <= words_d;
            shift_q <= shift_d;
        end
    end

    // Bytes shift in from the right; a partial word is left-justified on flush.
    assign pad = 2'd0 - cnt_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        waddr_d      = waddr_q;
        words_d      = words_q;
        shift_d      = shift_q;
        we           = 1'b0;
        wdata        = shift_q << {pad, 3'b000};
        load_ready_o = 1'b0;
        if (state_q == LOAD) load_ready_o = ~waddr_q[AW];
        if (load_start_i) begin
            state_d = LOAD;
            cnt_d   = '0;
            waddr_d = '0;
            words_d = '0;
            shift_d = '0;
        end else if (state_q == LOAD) begin
            if (load_valid_i && load_ready_o) begin
                shift_d = {shift_q[23:0], load_byte_i};
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    we      = 1'b1;
                    wdata   = {shift_q[23:0], load_byte_i};
                    waddr_d = waddr_q + (AW+1)'(1);
                    words_d = words_q + (AW+1)'(1);
                    shift_d = '0;
                    if (waddr_d[AW]) state_d = RUN;
                end
            end
            if (load_end_i && state_d == LOAD) state_d = (cnt_d == 2'd0) ? RUN : FLUSH;
        end else if (state_q == FLUSH) begin
            we      = 1'b1;
            words_d = words_q + (AW+1)'(1);
            cnt_d   = '0;
            shift_d = '0;
            state_d = RUN;
        end
    end

    inst_mem_array #(.AW(AW)) u_mem (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (waddr_q[AW-1:0]),
        .wdata_i (wdata),
        .raddr_i (addr_i[AW+1:2]),
        .rdata_o (rdata)
    );

    assign unused_addr    = &{1'b0, addr_i[1:0]};
    assign run_o          = (state_q == RUN);
    assign words_loaded_o = words_q;
    assign inst_o         = (run_o && ce_i && addr_i[31:AW+2] == '0) ? rdata : ZeroWord;
endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: directed scoreboard bench for the instruction ROM loader.
module tb_inst_rom_loader;
    localparam int AW = 8;
    logic        clk = 1'b0, rst_ni = 1'b0, ce = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] inst;
    logic        load_start = 1'b0, load_valid = 1'b0, load_end = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        load_ready, run;
    logic [AW:0] words_loaded;
    logic [31:0] sb [$];
    logic [31:0] w, keep;
    int          n_tests = 0, n_fail = 0;

    inst_rom_loader #(.AW(AW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .ce_i           (ce),
        .addr_i         (addr),
        .inst_o         (inst),
        .load_start_i   (load_start),
        .load_valid_i   (load_valid),
        .load_byte_i    (ld_byte),
        .load_ready_o   (load_ready),
        .load_end_i     (load_end),
        .run_o          (run),
        .words_loaded_o (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        load_valid = 1'b1;
        ld_byte    = b;
        cyc();
        load_valid = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] v);
        put(v[31:24]); put(v[23:16]); put(v[15:8]); put(v[7:0]);
        sb.push_back(v);
    endtask

    task automatic start();
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
    endtask

    task automatic finish_load();
        load_end = 1'b1;
        cyc();
        load_end = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] a);
        addr = a;
        #1;
        chk(tag, inst, sb.pop_front());
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7) + (i >> 8) + 3);
    endfunction

    initial begin
        cyc(); cyc();
        rst_ni = 1'b1;
        chk("rst_inst", inst, 32'h0);
        chk("rst_run", {31'b0, run}, 32'd0);
        chk("rst_ready", {31'b0, load_ready}, 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        cyc();
        chk("idle_run", {31'b0, run}, 32'd0);

        start();
        chk("load_ready", {31'b0, load_ready}, 32'd1);
        chk("load_inst_gated", inst, 32'h0);
        put_word(32'h34010005);
        put_word(32'h34020007);
        finish_load();
        chk("two_run", {31'b0, run}, 32'd1);
        chk("two_words", 32'(words_loaded), 32'd2);
        chk("run_ready", {31'b0, load_ready}, 32'd0);
        keep = sb[1];
        fetch("two_w0", 32'd0);
        fetch("two_w1", 32'd4);
        sb.push_back(keep);
        fetch("two_w1_unaligned", 32'd6);

        start();
        put(8'hAA); put(8'hBB); put(8'hCC);
        finish_load();
        chk("flush_run", {31'b0, run}, 32'd0);
        chk("flush_ready", {31'b0, load_ready}, 32'd0);
        cyc();
        chk("flush_run_after", {31'b0, run}, 32'd1);
        chk("flush_words", 32'(words_loaded), 32'd1);
        sb.push_back(32'hAABBCC00);
        fetch("flush_w0", 32'd0);

        start();
        w = 32'h12345678;
        for (int i = 0; i < 8; i++) begin
            load_valid = (i % 2 == 0);
            ld_byte    = (i % 2 == 0) ? w[31 - 8 * (i / 2) -: 8] : 8'hFF;
            cyc();
        end
        load_valid = 1'b0;
        sb.push_back(w);
        finish_load();
        chk("bp_words", 32'(words_loaded), 32'd1);
        fetch("bp_w0", 32'd0);
        ce = 1'b0;
        addr = 32'd0;
        #1 chk("ce_gate", inst, 32'h0);
        ce = 1'b1;
        addr = 32'h0000_0400;
        #1 chk("oor_gate", inst, 32'h0);

        start();
        for (int k = 0; k < 256; k++) begin
            for (int j = 0; j < 4; j++) begin
                w[31 - 8 * j -: 8] = pat(4 * k + j);
                chk("full_ready", {31'b0, load_ready}, 32'd1);
                put(pat(4 * k + j));
            end
            sb.push_back(w);
        end
        chk("full_ready_drop", {31'b0, load_ready}, 32'd0);
        chk("full_run", {31'b0, run}, 32'd1);
        chk("full_words", 32'(words_loaded), 32'd256);
        put(8'hEE);
        chk("full_extra_words", 32'(words_loaded), 32'd256);
        for (int k = 0; k < 256; k++) fetch("full_word", 32'(4 * k));

        start();
        put(8'h11); put(8'h22);
        load_start = 1'b1;
        load_valid = 1'b1;
        ld_byte    = 8'h33;
        cyc();
        load_start = 1'b0;
        load_valid = 1'b0;
        put_word(32'h44556677);
        finish_load();
        chk("restart_words", 32'(words_loaded), 32'd1);
        fetch("restart_w0", 32'd0);
        sb.push_back({pat(4), pat(5), pat(6), pat(7)});
        fetch("restart_w1_kept", 32'd4);

        start();
        put_word(32'hDEADBEEF);
        chk("pre_rst_words", 32'(words_loaded), 32'd1);
        put(8'h01); put(8'h02);
        chk("pre_rst_ready", {31'b0, load_ready}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_ready", {31'b0, load_ready}, 32'd0);
        chk("async_words", 32'(words_loaded), 32'd0);
        chk("async_run", {31'b0, run}, 32'd0);
        chk("async_inst", inst, 32'h0);
        cyc();
        rst_ni = 1'b1;
        cyc();
        chk("post_rst_run", {31'b0, run}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
